// File: rtl/mst_fifo_chn_sched_if.sv
// -----------------------------------------------------------------------------
// mst_fifo_chn_sched_if
// Bundles the signals between the FT600 master FSM / status path and the
// channel scheduler.
//   master modport : the FT600 master side. It drives status, levels, quota and
//                    beat/done strobes, and receives the grant.
//   slave modport  : the scheduler. It receives status, levels, quota and
//                    strobes, and drives the grant.
// Signals:
//   mltcn, stat_vld, stat_rxf_n[3:0], stat_txe_n[3:0], ififoafull[3:0],
//   src_nempt[3:0], quota[QW-1:0], txn_beat, txn_done        (to scheduler)
//   grant_vld, grant_chn[1:0], grant_dir, quota_hit,
//   beat_cnt[QW-1:0]                                          (from scheduler)
// -----------------------------------------------------------------------------
interface mst_fifo_chn_sched_if #(
    parameter int QW = 8
);
    logic          mltcn;
    logic          stat_vld;
    logic [3:0]    stat_rxf_n;
    logic [3:0]    stat_txe_n;
    logic [3:0]    ififoafull;
    logic [3:0]    src_nempt;
    logic [QW-1:0] quota;
    logic          txn_beat;
    logic          txn_done;
    logic          grant_vld;
    logic [1:0]    grant_chn;
    logic          grant_dir;
    logic          quota_hit;
    logic [QW-1:0] beat_cnt;

    modport master (
        output mltcn, stat_vld, stat_rxf_n, stat_txe_n, ififoafull, src_nempt,
               quota, txn_beat, txn_done,
        input  grant_vld, grant_chn, grant_dir, quota_hit, beat_cnt
    );

    modport slave (
        input  mltcn, stat_vld, stat_rxf_n, stat_txe_n, ififoafull, src_nempt,
               quota, txn_beat, txn_done,
        output grant_vld, grant_chn, grant_dir, quota_hit, beat_cnt
    );
endinterface

// File: rtl/mst_fifo_chn_sched.sv
// -----------------------------------------------------------------------------
// mst_fifo_chn_sched
// Picks the next channel (0..3) and direction (0 = read FT600->FPGA,
// 1 = write FPGA->FT600) for the FT600 master FSM. The choice uses the latched
// FT600 status word and the internal FIFO/prefetch levels. Channels are scanned
// round-robin from rr_ptr. When a channel can go both ways, the direction
// alternates. A per-grant beat counter raises quota_hit once the quota is
// reached. In 245 mode (mltcn=0) only channel 0 is considered.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : mst_fifo_chn_sched_if.slave (status/levels/strobes in, grant out)
// -----------------------------------------------------------------------------
module mst_fifo_chn_sched #(
    parameter int QW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mst_fifo_chn_sched_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_EVAL  = 3'b010,
        S_GRANT = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    rxf_q, rxf_d;
    logic [3:0]    txe_q, txe_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]    last_dir_q, last_dir_d;
    logic          grant_vld_q, grant_vld_d;
    logic [1:0]    grant_chn_q, grant_chn_d;
    logic          grant_dir_q, grant_dir_d;
    logic          quota_hit_q, quota_hit_d;
    logic [QW-1:0] beat_cnt_q, beat_cnt_d;

    logic [3:0]    chn_mask_s;
    logic [3:0]    rd_ok_s;
    logic [3:0]    wr_ok_s;
    logic          win_vld_s;
    logic [1:0]    win_chn_s;
    logic          win_dir_s;

    // Per-channel eligibility from latched status; 245 mode masks off ch1..3
    always_comb begin
        chn_mask_s = bus.mltcn ? 4'hF : 4'h1;
        rd_ok_s    = ~rxf_q & ~bus.ififoafull & chn_mask_s;
        wr_ok_s    = ~txe_q & bus.src_nempt & chn_mask_s;
    end

    // Round-robin scan starting at rr_ptr; first eligible channel wins
    always_comb begin
        logic [1:0] idx;
        win_vld_s = 1'b0;
        win_chn_s = 2'd0;
        win_dir_s = 1'b0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!win_vld_s && (rd_ok_s[idx] || wr_ok_s[idx])) begin
                win_vld_s = 1'b1;
                win_chn_s = idx;
                // both directions possible: alternate against the last one used
                win_dir_s = (rd_ok_s[idx] && wr_ok_s[idx]) ? ~last_dir_q[idx]
                                                           : wr_ok_s[idx];
            end else begin
                idx = rr_ptr_q + 2'(i);
            end
        end
    end

    // Next-state, status latch, grant and beat-counter logic
    always_comb begin
        state_d     = state_q;
        rxf_d       = bus.stat_vld ? bus.stat_rxf_n : rxf_q;
        txe_d       = bus.stat_vld ? bus.stat_txe_n : txe_q;
        rr_ptr_d    = bus.mltcn ? rr_ptr_q : 2'd0;
        last_dir_d  = last_dir_q;
        grant_vld_d = grant_vld_q;
        grant_chn_d = grant_chn_q;
        grant_dir_d = grant_dir_q;
        quota_hit_d = quota_hit_q;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            S_IDLE: begin
                state_d = bus.stat_vld ? S_EVAL : S_IDLE;
            end
            S_EVAL: begin
                if (win_vld_s) begin
                    state_d     = S_GRANT;
                    grant_vld_d = 1'b1;
                    grant_chn_d = win_chn_s;
                    grant_dir_d = win_dir_s;
                    beat_cnt_d  = {QW{1'b0}};
                    quota_hit_d = 1'b0;
                    // consume the status bit so it cannot re-grant without a new strobe
                    if (win_dir_s) begin
                        txe_d[win_chn_s] = 1'b1;
                    end else begin
                        rxf_d[win_chn_s] = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (bus.txn_beat && (beat_cnt_q != {QW{1'b1}})) begin
                    beat_cnt_d = beat_cnt_q + QW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
                // compare against the updated count so quota_hit lines up with beat_cnt
                quota_hit_d = quota_hit_q |
                              ((bus.quota != {QW{1'b0}}) && (beat_cnt_d >= bus.quota));
                if (bus.txn_done) begin
                    state_d                 = S_IDLE;
                    grant_vld_d             = 1'b0;
                    quota_hit_d             = 1'b0;
                    last_dir_d[grant_chn_q] = grant_dir_q;
                    rr_ptr_d                = bus.mltcn ? (grant_chn_q + 2'd1) : 2'd0;
                end else begin
                    state_d = S_GRANT;
                end
            end
            default: begin
                state_d     = S_IDLE;
                grant_vld_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rxf_q       <= 4'hF;
            txe_q       <= 4'hF;
            rr_ptr_q    <= 2'd0;
            last_dir_q  <= 4'h0;
            grant_vld_q <= 1'b0;
            grant_chn_q <= 2'd0;
            grant_dir_q <= 1'b0;
            quota_hit_q <= 1'b0;
            beat_cnt_q  <= {QW{1'b0}};
        end else begin
            state_q     <= state_d;
            rxf_q       <= rxf_d;
            txe_q       <= txe_d;
            rr_ptr_q    <= rr_ptr_d;
            last_dir_q  <= last_dir_d;
            grant_vld_q <= grant_vld_d;
            grant_chn_q <= grant_chn_d;
            grant_dir_q <= grant_dir_d;
            quota_hit_q <= quota_hit_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign bus.grant_vld = grant_vld_q;
    assign bus.grant_chn = grant_chn_q;
    assign bus.grant_dir = grant_dir_q;
    assign bus.quota_hit = quota_hit_q;
    assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mst_fifo_chn_sched.sv
// -----------------------------------------------------------------------------
// tb_mst_fifo_chn_sched
// Directed bench for the FT600 channel scheduler. Inputs change on the falling
// edge and outputs are sampled on the falling edge. Expected values are worked
// out by hand.
// -----------------------------------------------------------------------------
module tb_mst_fifo_chn_sched;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mst_fifo_chn_sched_if #(.QW(8)) bus_if ();

    mst_fifo_chn_sched #(.QW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n               = 1'b0;
        bus_if.mltcn        = 1'b1;
        bus_if.stat_vld     = 1'b0;
        bus_if.stat_rxf_n   = 4'hF;
        bus_if.stat_txe_n   = 4'hF;
        bus_if.ififoafull   = 4'h0;
        bus_if.src_nempt    = 4'h0;
        bus_if.quota        = 8'd0;
        bus_if.txn_beat     = 1'b0;
        bus_if.txn_done     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One-cycle status strobe; returns one falling edge later (FSM now in EVAL)
    task automatic strobe(input logic [3:0] rxf, input logic [3:0] txe);
        bus_if.stat_vld   = 1'b1;
        bus_if.stat_rxf_n = rxf;
        bus_if.stat_txe_n = txe;
        @(negedge clk);
        bus_if.stat_vld = 1'b0;
    endtask

    // Strobe status and check that the grant appears two edges after the strobe
    task automatic grant_exp(input string tag, input logic [3:0] rxf, input logic [3:0] txe,
                             input logic [1:0] chn, input logic dir);
        strobe(rxf, txe);
        chk({tag, "_vld_early"}, {31'd0, bus_if.grant_vld}, 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, {31'd0, bus_if.grant_vld}, 32'd1);
        chk({tag, "_chn"}, {30'd0, bus_if.grant_chn}, {30'd0, chn});
        chk({tag, "_dir"}, {31'd0, bus_if.grant_dir}, {31'd0, dir});
        chk({tag, "_cnt0"}, {24'd0, bus_if.beat_cnt}, 32'd0);
    endtask

    task automatic done(input string tag);
        bus_if.txn_done = 1'b1;
        @(negedge clk);
        bus_if.txn_done = 1'b0;
        chk({tag, "_vld_off"}, {31'd0, bus_if.grant_vld}, 32'd0);
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b1;
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // reset state
        do_reset();
        chk("rst_vld",  {31'd0, bus_if.grant_vld}, 32'd0);
        chk("rst_chn",  {30'd0, bus_if.grant_chn}, 32'd0);
        chk("rst_dir",  {31'd0, bus_if.grant_dir}, 32'd0);
        chk("rst_hit",  {31'd0, bus_if.quota_hit}, 32'd0);
        chk("rst_cnt",  {24'd0, bus_if.beat_cnt},  32'd0);

        // 1: only ch2 has RX data
        grant_exp("t1", 4'b1011, 4'hF, 2'd2, 1'b0);
        done("t1");
        // consumed status must not re-grant without a new strobe
        repeat (3) @(negedge clk);
        chk("t1_stale", {31'd0, bus_if.grant_vld}, 32'd0);

        // 2: round robin over four read-ready channels
        do_reset();
        for (int k = 0; k < 5; k++) begin
            grant_exp($sformatf("t2_%0d", k), 4'h0, 4'hF, rr_exp[k], 1'b0);
            done($sformatf("t2_%0d", k));
        end

        // 3: ch1 can read and write; direction alternates
        do_reset();
        bus_if.src_nempt = 4'b0010;
        grant_exp("t3a", 4'b1101, 4'b1101, 2'd1, 1'b1);
        done("t3a");
        grant_exp("t3b", 4'b1101, 4'b1101, 2'd1, 1'b0);
        done("t3b");
        bus_if.src_nempt = 4'h0;

        // 4: quota of 4 beats, 6 beats moved
        do_reset();
        bus_if.quota = 8'd4;
        grant_exp("t4", 4'b1110, 4'hF, 2'd0, 1'b0);
        bus_if.txn_beat = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("t4_cnt%0d", k), {24'd0, bus_if.beat_cnt}, k);
            chk($sformatf("t4_hit%0d", k), {31'd0, bus_if.quota_hit}, (k >= 4) ? 32'd1 : 32'd0);
        end
        bus_if.txn_beat = 1'b0;
        @(negedge clk);
        chk("t4_cnt_hold", {24'd0, bus_if.beat_cnt}, 32'd6);
        chk("t4_hit_hold", {31'd0, bus_if.quota_hit}, 32'd1);
        done("t4");
        chk("t4_hit_clr", {31'd0, bus_if.quota_hit}, 32'd0);
        bus_if.quota = 8'd0;

        // 5: 245 mode, only ch0 served
        do_reset();
        bus_if.mltcn = 1'b0;
        grant_exp("t5a", 4'b1100, 4'hF, 2'd0, 1'b0);
        done("t5a");
        grant_exp("t5b", 4'b1100, 4'hF, 2'd0, 1'b0);
        done("t5b");
        bus_if.ififoafull = 4'b0001;
        strobe(4'b1100, 4'hF);
        repeat (3) @(negedge clk);
        chk("t5_afull_nogrant", {31'd0, bus_if.grant_vld}, 32'd0);
        bus_if.ififoafull = 4'h0;
        bus_if.mltcn      = 1'b1;

        // 6: asynchronous reset in the middle of a grant
        do_reset();
        grant_exp("t6", 4'b0111, 4'hF, 2'd3, 1'b0);
        bus_if.txn_beat = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.txn_beat = 1'b0;
        chk("t6_cnt_pre", {24'd0, bus_if.beat_cnt}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_vld", {31'd0, bus_if.grant_vld}, 32'd0);
        chk("t6_async_cnt", {24'd0, bus_if.beat_cnt},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_nogrant", {31'd0, bus_if.grant_vld}, 32'd0);
        grant_exp("t6b", 4'b0111, 4'hF, 2'd3, 1'b0);
        done("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
